izigzag: RTL and testbench

- Inverse zigzag reorder: the reader counterpart of the zigzag stage.
- Accepts 64-sample blocks in JPEG zigzag order and emits them in 8x8 raster (row-major) order.
- Sits on the decode/verification path, ahead of the inverse DCT. It uses the same din/din_valid -> dout/dout_valid streaming style as the other JPEG stages, with no backpressure.
- Internally a two-bank ping-pong buffer, so streaming runs continuously at up to one sample per clock.

---
 rtl/jpeg_pkg.sv | 17 +
 rtl/jpeg_dpram.sv | 20 ++
 rtl/izigzag.sv | 84 ++++++++
 tb/tb_izigzag.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared JPEG block constants and the zigzag scan table
package jpeg_pkg;
  localparam int BLK_SIZE = 64;
  typedef logic [5:0] blk_idx_t;
  localparam blk_idx_t LAST_IDX = 6'd63;
  // ZZ[k] is the raster index of the k-th sample in zigzag order
  localparam blk_idx_t ZZ [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/jpeg_dpram.sv
// jpeg_dpram: simple dual-port RAM, synchronous write, registered read
// Ports: clk; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata read data one cycle later
module jpeg_dpram #(
  parameter int DW = 8,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/izigzag.sv
// izigzag: inverse zigzag reorder, zigzag-order 64-sample blocks in, raster order out
// Ports: clk; nrst sync active-low reset; din/din_valid zigzag-order input;
//        dout/dout_valid raster-order output; dout_last on raster index 63;
//        busy while a block is buffered, draining or partially written
module izigzag import jpeg_pkg::*; #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          dout_last,
  output logic          busy
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t r_state, w_state_nxt;
  blk_idx_t r_wr_cnt, r_rd_cnt, w_rd_cnt_nxt;
  logic r_wr_bank, r_rd_bank, w_rd_bank_nxt;
  logic [1:0] r_full, w_full_nxt;
  logic w_wr_done, w_rd_en, w_rd_done;
  logic r_dout_valid, r_rd_last;
  logic [DW-1:0] w_rdata;
  assign w_wr_done = din_valid && (r_wr_cnt == LAST_IDX);
  // a full bank seen in IDLE launches its first read at once, saving a cycle of latency
  always_comb begin
    w_state_nxt = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    w_rd_bank_nxt = r_rd_bank;
    w_rd_en = 1'b0;
    w_rd_done = 1'b0;
    if (r_state == DRAIN || r_full[r_rd_bank]) begin
      w_rd_en = 1'b1;
      w_state_nxt = DRAIN;
      w_rd_cnt_nxt = r_rd_cnt + 6'd1;
      if (r_rd_cnt == LAST_IDX) begin
        w_rd_done = 1'b1;
        w_rd_bank_nxt = ~r_rd_bank;
        w_state_nxt = r_full[~r_rd_bank] ? DRAIN : IDLE;
      end
    end
  end
  // writer and reader always touch different banks, so both updates apply
  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_wr_cnt <= '0;
      r_wr_bank <= 1'b0;
      r_rd_cnt <= '0;
      r_rd_bank <= 1'b0;
      r_full <= '0;
      r_dout_valid <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_full <= w_full_nxt;
      r_wr_cnt <= din_valid ? r_wr_cnt + 6'd1 : r_wr_cnt;
      r_wr_bank <= w_wr_done ? ~r_wr_bank : r_wr_bank;
      r_dout_valid <= w_rd_en;
      r_rd_last <= w_rd_done;
    end
  end
  jpeg_dpram #(.DW(DW), .DEPTH(2 * BLK_SIZE)) u_mem (
    .clk     (clk),
    .i_we    (din_valid),
    .i_waddr ({r_wr_bank, ZZ[r_wr_cnt]}),
    .i_wdata (din),
    .i_raddr ({r_rd_bank, r_rd_cnt}),
    .o_rdata (w_rdata)
  );
  // RAM read register has no reset, so data is masked outside valid cycles
  assign dout = r_dout_valid ? w_rdata : '0;
  assign dout_valid = r_dout_valid;
  assign dout_last = r_dout_valid & r_rd_last;
  assign busy = (|r_full) | (r_state == DRAIN) | r_dout_valid | (r_wr_cnt != '0);
endmodule

// File: tb/tb_izigzag.sv
// tb_izigzag: randomized self-checking bench for izigzag against a cycle-scheduled reference model
module tb_izigzag;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic dout_valid, dout_last, busy;

  izigzag #(.DW(DW)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    logic [DW-1:0] v;
    logic last;
  } exp_t;
  exp_t q[$];
  int zz[64];
  logic [DW-1:0] blk[64];
  int wcnt = 0;
  int prev_end = -1;
  logic mon = 1'b0;
  logic ev;
  logic [DW-1:0] cap[$];
  int first_valid = -1;
  int last_cyc = -1;
  int nlast = 0;
  int run = 0;
  int max_run = 0;
  logic busy_at_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a completed block drains 2 cycles after its last input, but never before the previous block ends
  task automatic schedule(input int c);
    logic [DW-1:0] raster[64];
    int s;
    for (int k = 0; k < 64; k++) raster[zz[k]] = blk[k];
    s = (c + 2 > prev_end + 1) ? c + 2 : prev_end + 1;
    for (int n = 0; n < 64; n++) q.push_back('{s + n, raster[n], n == 63});
    prev_end = s + 63;
  endtask

  task automatic put(input logic [DW-1:0] d);
    din_valid = 1'b1;
    din = d;
    blk[wcnt] = d;
    if (wcnt == 63) schedule(cyc);
    wcnt = (wcnt + 1) % 64;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    int rc;
    rc = cyc;
    nrst = 1'b0;
    din_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    while (q.size() > 0 && q[$].c > rc) void'(q.pop_back());
    wcnt = 0;
    prev_end = -1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("drain_timeout_pending", q.size(), 0);
    idle(3);
  endtask

  task automatic clear_cap();
    cap.delete();
    first_valid = -1;
    nlast = 0;
    max_run = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon) begin
        ev = (q.size() > 0) && (q[0].c == cyc);
        checks++;
        if (dout_valid !== ev) begin
          errors++;
          $display("FAIL dout_valid (cycle %0d): got %b expected %b", cyc, dout_valid, ev);
        end
        checks++;
        if (ev) begin
          if (dout !== q[0].v || dout_last !== q[0].last) begin
            errors++;
            $display("FAIL dout (cycle %0d): got %0d last %b expected %0d last %b",
                     cyc, dout, dout_last, q[0].v, q[0].last);
          end
          void'(q.pop_front());
        end else if (dout !== '0 || dout_last !== 1'b0) begin
          errors++;
          $display("FAIL idle_dout (cycle %0d): got %0d last %b expected 0 last 0", cyc, dout, dout_last);
        end
        if (dout_valid === 1'b1) begin
          cap.push_back(dout);
          if (first_valid < 0) first_valid = cyc;
          run++;
          if (run > max_run) max_run = run;
          if (dout_last === 1'b1) begin
            nlast++;
            last_cyc = cyc;
            busy_at_last = busy;
          end
        end else run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, p, c_last, n;
    p = 0;
    for (int s = 0; s < 15; s++)
      for (int i = 0; i < 8; i++) begin
        r = (s % 2 == 1) ? i : 7 - i;
        if (s - r >= 0 && s - r < 8) begin
          zz[p] = r * 8 + (s - r);
          p++;
        end
      end
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    mon = 1'b1;
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dout", dout, 0);

    for (int i = 0; i < 200; i++) begin
      idle(1);
      chk("idle_outputs", {dout_valid, busy, dout}, 0);
    end

    clear_cap();
    for (int k = 0; k < 64; k++) begin
      if (k == 63) c_last = cyc;
      put(DW'(k));
    end
    idle(70);
    chk("single_count", cap.size(), 64);
    chk("single_latency", first_valid, c_last + 2);
    chk("single_r2", cap[2], 5);
    chk("single_r8", cap[8], 2);
    chk("single_r9", cap[9], 4);
    chk("single_r10", cap[10], 7);
    chk("single_r16", cap[16], 3);
    chk("single_r63", cap[63], 63);
    chk("single_nlast", nlast, 1);
    chk("single_last_pos", last_cyc, first_valid + 63);

    clear_cap();
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 64; k++) put(DW'(b * 64 + k));
    drain();
    chk("b2b_count", cap.size(), 192);
    chk("b2b_run", max_run, 192);
    chk("b2b_blk1_r2", cap[66], 69);
    chk("b2b_nlast", nlast, 3);

    clear_cap();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 64; k++) begin
        while ($urandom_range(0, 99) >= 30) idle(1);
        put(DW'($urandom));
      end
    drain();
    chk("rand_nlast", nlast, 4);
    chk("rand_busy_at_last", busy_at_last, 1);
    while (cyc < last_cyc + 2) begin @(posedge clk); #1; end
    chk("rand_busy_after", busy, 0);

    for (int k = 0; k < 40; k++) put(DW'($urandom));
    chk("partial_busy", busy, 1);
    do_reset();
    chk("partial_rst_valid", dout_valid, 0);
    chk("partial_rst_busy", busy, 0);
    clear_cap();
    for (int k = 0; k < 64; k++) put(DW'(k));
    drain();
    chk("partial_count", cap.size(), 64);
    n = 0;
    for (int k = 0; k < 64; k++) if (cap[zz[k]] !== DW'(k)) n++;
    chk("partial_golden_bad", n, 0);

    clear_cap();
    for (int k = 0; k < 64; k++) put(DW'(100 + k));
    n = 0;
    while (cap.size() < 20 && n < 200) begin @(posedge clk); #1; n++; end
    chk("abort_reached_20", cap.size() >= 20, 1);
    do_reset();
    chk("abort_rst_valid", dout_valid, 0);
    idle(80);
    chk("abort_count", cap.size(), 21);
    chk("abort_nlast", nlast, 0);
    clear_cap();
    for (int k = 0; k < 64; k++) put(DW'(k * 3));
    drain();
    chk("after_abort_count", cap.size(), 64);
    chk("after_abort_r0", cap[0], 0);
    chk("after_abort_r1", cap[1], 3);
    chk("after_abort_r8", cap[8], 6);
    chk("after_abort_nlast", nlast, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
